// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and
// requester/index sizing.
package arb_pkg;
    localparam int ARB_N = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/round_robin_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface round_robin_arbiter_8_if;
    import arb_pkg::*;

    logic [ARB_N-1:0] req;
    logic             done;
    logic [ARB_N-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout;

    modport master (
        output req, done,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, grant_valid, timeout
    );
endinterface

// File: rtl/rr_priority_encoder.sv
// Stateless round-robin pick: first set request scanning upward from ptr,
// wrapping from the top requester back to 0.
module rr_priority_encoder
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [ARB_N-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [IDX_W-1:0] pos;

    always_comb begin
        pos = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < ARB_N; i++) begin
            // 3-bit add wraps 7 -> 0 for free
            pos = ptr + i[IDX_W-1:0];
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
        onehot = any ? (ARB_N'(1) << idx) : '0;
    end
endmodule

// File: rtl/round_robin_arbiter_8.sv
// Round-robin arbiter for 8 requesters with per-owner hold limit and a
// mandatory idle cycle between owners.
module round_robin_arbiter_8
    import arb_pkg::*;
#(
    parameter int size     = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    round_robin_arbiter_8_if.slave  bus
);
    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [7:0]       hold_cnt_q;
    logic [7:0]       hold_cnt_d;
    logic [size-1:0]  grant_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             timeout_q;

    logic [ARB_N-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             hold_hit;
    logic             release_now;

    rr_priority_encoder u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign owner_req   = bus.req[idx_q];
    assign hold_hit    = (hold_cnt_q == 8'(HOLD_MAX - 1));
    assign release_now = bus.done || !owner_req || hold_hit;
    assign hold_cnt_d  = hold_cnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q    <= GRANT;
                        grant_q    <= pick_onehot;
                        idx_q      <= pick_idx;
                        valid_q    <= 1'b1;
                        hold_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state_q    <= IDLE;
                        grant_q    <= '0;
                        idx_q      <= '0;
                        valid_q    <= 1'b0;
                        hold_cnt_q <= '0;
                        ptr_q      <= idx_q + 3'd1;
                        // only a pure hold-limit release counts as a timeout
                        timeout_q  <= hold_hit && !bus.done && owner_req;
                    end else begin
                        hold_cnt_q <= hold_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Directed bench for round_robin_arbiter_8: driver queues expected outputs,
// monitor compares them one cycle later.
module tb_round_robin_arbiter_8;
    typedef struct packed {
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t  q[$];
    string tags[$];

    round_robin_arbiter_8_if bus();

    round_robin_arbiter_8 #(.size(8), .HOLD_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        exp_t  e;
        exp_t  a;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                t = tags.pop_front();
                a = {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got grant=%b idx=%0d valid=%b timeout=%b, want grant=%b idx=%0d valid=%b timeout=%b",
                             t, a.g, a.idx, a.v, a.to, e.g, e.idx, e.v, e.to);
                end
            end
        end
    end

    task automatic step(input logic [7:0] r, input logic d, input logic [7:0] g,
                        input logic [2:0] i, input logic v, input logic to, input string tag);
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        q.push_back({g, i, v, to});
        tags.push_back(tag);
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if ({bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout} !== 13'b0) begin
            errors++;
            $display("FAIL %s: got grant=%b idx=%0d valid=%b timeout=%b, want all zero",
                     tag, bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        #1 check_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : driver
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        #1 check_idle("power-on reset");

        // single requester, 1-cycle latency
        do_reset();
        step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "req0 grant");
        step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "req0 hold");
        step(8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "req0 done release");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "idle no req");

        // full rotation with done each grant cycle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(8'hFF, 1'b0, 8'(1) << i, 3'(i), 1'b1, 1'b0, "rotate grant");
            step(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "rotate idle gap");
        end
        step(8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "rotate wrap to 0");
        step(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "rotate idle gap");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "idle no req");

        // ptr=1 now; grant 5 to move ptr to 6, then wrap pick
        step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "req5 grant");
        step(8'h20, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "req5 release");
        step(8'h03, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "wrap from ptr6");
        step(8'h03, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "wrap release");
        step(8'h03, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, "ptr1 picks req1");
        step(8'h03, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "req1 release");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "idle no req");

        // hold limit: 15 grant cycles, then timeout idle, then re-grant
        step(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "hold req3 grant");
        for (int k = 0; k < 14; k++)
            step(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "hold req3 held");
        step(8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, "hold timeout pulse");
        step(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "req3 regrant");
        step(8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "req3 release");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "idle no req");

        // owner 5 at limit with req dropped and done: no timeout; others ignored
        step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "req5 grant");
        for (int k = 0; k < 14; k++)
            step((k % 2) ? 8'hFF : 8'h25, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "req5 held, others toggle");
        step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "limit with done suppresses timeout");
        step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "done in idle ignored");
        step(8'h40, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0, "idle grant despite done");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "dropped req release");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "idle no req");

        // asynchronous reset mid-grant
        step(8'hFF, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, "ptr7 grant");
        @(posedge clk);
        #3;
        rst     = 1'b1;
        bus.req = '0;
        #1 check_idle("async reset mid-grant");
        @(negedge clk);
        rst = 1'b0;
        step(8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, "req7 after reset");
        step(8'h80, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "req7 release");
        step(8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "ptr0 after reset picks 0");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "dropped req release");

        for (int k = 0; k < 20 && q.size() > 0; k++)
            @(posedge clk);
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
